// File: rtl/tbcm_arbiter_pkg.sv
// Shared arbiter types and helpers: one-hot rotation and one-hot checking,
// used by the round-robin and weighted round-robin arbiters.
package tbcm_arbiter_pkg;

  localparam int TBCM_ARB_MAX_REQ = 32;

  typedef logic [TBCM_ARB_MAX_REQ-1:0]         tbcm_arb_vec_t;
  typedef logic [$clog2(TBCM_ARB_MAX_REQ)-1:0] tbcm_rr_index_t;

  // Rotate a vector left by one position inside its low n bits.
  function automatic tbcm_arb_vec_t tbcm_onehot_rotl(input tbcm_arb_vec_t vec,
                                                     input int unsigned   n);
    tbcm_arb_vec_t res;
    res = '0;
    for (int unsigned i = 0; i < n; i++) begin
      res[(i + 1) % n] = vec[i];
    end
    return res;
  endfunction

  function automatic logic tbcm_is_onehot(input tbcm_arb_vec_t vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < TBCM_ARB_MAX_REQ; i++) begin
      if (vec[i]) cnt++;
    end
    return cnt == 1;
  endfunction

endpackage

// File: rtl/tbcm_rr_picker.sv
// Combinational picker: first set request strictly after the one-hot pointer,
// wrapping; returns the pointer bit itself if it is the only requester.
module tbcm_rr_picker
  import tbcm_arbiter_pkg::*;
#(
  parameter int REQUESTS = 2
) (
  input  logic [REQUESTS-1:0] request,
  input  logic [REQUESTS-1:0] pointer,
  output logic [REQUESTS-1:0] pick
);

  tbcm_arb_vec_t cand;
  logic          found;

  // Walk the candidate one-hot around the ring starting just above the pointer.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = tbcm_onehot_rotl(tbcm_arb_vec_t'(pointer), REQUESTS);
    for (int i = 0; i < REQUESTS; i++) begin
      if (!found && ((cand[REQUESTS-1:0] & request) != '0)) begin
        pick  = cand[REQUESTS-1:0];
        found = 1'b1;
      end
      cand = tbcm_onehot_rotl(cand, REQUESTS);
    end
  end

endmodule

// File: rtl/tbcm_weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter: combinational grant, owner keeps up to weight+1 grants,
// optional hold-until-free lock; TBCM_WRR_ARBITER_URGENT_EN adds an urgent request class.
module tbcm_weighted_round_robin_arbiter
  import tbcm_arbiter_pkg::*;
#(
  parameter int                  REQUESTS      = 2,
  parameter int                  WEIGHT_WIDTH  = 4,
  parameter bit                  KEEP_RESULT   = 1'b1,
  parameter logic [REQUESTS-1:0] INITIAL_GRANT = REQUESTS'(1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REQUESTS-1:0]     i_request,
  input  logic [WEIGHT_WIDTH-1:0] i_weight [REQUESTS],
  input  logic [REQUESTS-1:0]     i_free,
`ifdef TBCM_WRR_ARBITER_URGENT_EN
  input  logic [REQUESTS-1:0]     i_urgent,
`endif
  output logic [REQUESTS-1:0]     o_grant
);

  localparam int IDX_W = (REQUESTS > 1) ? $clog2(REQUESTS) : 1;

  if (!tbcm_is_onehot(tbcm_arb_vec_t'(INITIAL_GRANT))) begin : g_bad_initial_grant
    $error("INITIAL_GRANT must be one-hot");
  end
  if (REQUESTS < 2 || REQUESTS > TBCM_ARB_MAX_REQ) begin : g_bad_requests
    $error("REQUESTS out of range");
  end

  logic [REQUESTS-1:0]     owner;
  logic [REQUESTS-1:0]     cls_req;
  logic [REQUESTS-1:0]     pick_all;
  logic [REQUESTS-1:0]     pick_sel;
  logic [REQUESTS-1:0]     winner;
  logic [REQUESTS-1:0]     grant;
  logic [WEIGHT_WIDTH-1:0] credit;
  logic [WEIGHT_WIDTH-1:0] load_weight;
  logic                    busy;
  logic                    grab;
  logic                    stay;
  tbcm_rr_index_t          win_idx;

  tbcm_rr_picker #(.REQUESTS(REQUESTS)) u_pick_all (
    .request (i_request),
    .pointer (owner),
    .pick    (pick_all)
  );

`ifdef TBCM_WRR_ARBITER_URGENT_EN
  logic [REQUESTS-1:0] urgent_req;
  logic [REQUESTS-1:0] pick_urgent;

  assign urgent_req = i_request & i_urgent;

  tbcm_rr_picker #(.REQUESTS(REQUESTS)) u_pick_urgent (
    .request (urgent_req),
    .pointer (owner),
    .pick    (pick_urgent)
  );

  // Any urgent request narrows the contest to the urgent set, preempting a normal owner.
  assign cls_req  = (urgent_req != '0) ? urgent_req : i_request;
  assign pick_sel = (urgent_req != '0) ? pick_urgent : pick_all;
`else
  assign cls_req  = i_request;
  assign pick_sel = pick_all;
`endif

  assign grab   = !busy && (i_request != '0);
  assign stay   = ((owner & cls_req) != '0) && (credit != '0);
  assign winner = stay ? owner : pick_sel;

  always_comb begin
    grant = '0;
    if (rst) begin
      grant = '0;
    end else if (grab) begin
      grant = winner;
    end else if (busy) begin
      grant = owner;
    end
  end

  assign o_grant = grant;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < REQUESTS; i++) begin
      if (winner[i]) win_idx = tbcm_rr_index_t'(i);
    end
  end

  assign load_weight = i_weight[win_idx[IDX_W-1:0]];

  // Weight is only sampled when the turn moves, so mid-turn edits wait for the next rotate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner  <= INITIAL_GRANT;
      credit <= '0;
    end else if (grab) begin
      if (stay) begin
        credit <= credit - 1'b1;
      end else begin
        owner  <= winner;
        credit <= load_weight;
      end
    end
  end

  if (KEEP_RESULT) begin : g_keep
    // Release wins over a new grab so a same-cycle grant+free never locks.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        busy <= 1'b0;
      end else if ((grant & i_free) != '0) begin
        busy <= 1'b0;
      end else if (grab) begin
        busy <= 1'b1;
      end
    end
  end else begin : g_no_keep
    logic unused_free;
    assign unused_free = ^i_free;
    assign busy        = 1'b0;
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(o_grant));

endmodule

// File: tb/tb_tbcm_weighted_round_robin_arbiter.sv
// Bench for the weighted round-robin arbiter: two instances (free-running and hold-until-free)
// checked every cycle against a turn/streak model, plus hand-computed grant sequences.
module tb_tbcm_weighted_round_robin_arbiter;

  localparam int N  = 4;
  localparam int WW = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req0, req1, free0, free1, urg0, urg1, gnt0, gnt1;
  logic [WW-1:0] wt0 [N];
  logic [WW-1:0] wt1 [N];

  int checks = 0;
  int errors = 0;

  // Model: current turn holder, grants taken beyond the first in this turn, allowed extras, lock.
  int m_owner [2];
  int m_extra [2];
  int m_allow [2];
  bit m_lock  [2];

  tbcm_weighted_round_robin_arbiter #(
    .REQUESTS(N), .WEIGHT_WIDTH(WW), .KEEP_RESULT(1'b0), .INITIAL_GRANT(4'b0001)
  ) dut0 (
    .clk      (clk),
    .rst      (rst),
    .i_request(req0),
    .i_weight (wt0),
    .i_free   (free0),
`ifdef TBCM_WRR_ARBITER_URGENT_EN
    .i_urgent (urg0),
`endif
    .o_grant  (gnt0)
  );

  tbcm_weighted_round_robin_arbiter #(
    .REQUESTS(N), .WEIGHT_WIDTH(WW), .KEEP_RESULT(1'b1), .INITIAL_GRANT(4'b0001)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .i_request(req1),
    .i_weight (wt1),
    .i_free   (free1),
`ifdef TBCM_WRR_ARBITER_URGENT_EN
    .i_urgent (urg1),
`endif
    .o_grant  (gnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int weight_of(input int d, input int i);
    return (d == 0) ? int'(wt0[i]) : int'(wt1[i]);
  endfunction

  // Who wins a contest from the model's point of view.
  task automatic model_arb(input int d, input logic [N-1:0] r, input logic [N-1:0] u,
                           output int win, output bit keep_turn);
    logic [N-1:0] cls;
    cls       = ((r & u) != '0) ? (r & u) : r;
    keep_turn = cls[m_owner[d]] && (m_extra[d] < m_allow[d]);
    win       = m_owner[d];
    if (!keep_turn) begin
      for (int k = N; k >= 1; k--) begin
        if (cls[(m_owner[d] + k) % N]) win = (m_owner[d] + k) % N;
      end
    end
  endtask

  task automatic model_grant(input int d, output logic [N-1:0] g);
    logic [N-1:0] r, u;
    int           win;
    bit           keep_turn;
    r = (d == 0) ? req0 : req1;
    u = (d == 0) ? urg0 : urg1;
    g = '0;
    if (rst) begin
      g = '0;
    end else if (m_lock[d]) begin
      g[m_owner[d]] = 1'b1;
    end else if (r != '0) begin
      model_arb(d, r, u, win, keep_turn);
      g[win] = 1'b1;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] r, u, f, g;
      int           win;
      bit           keep_turn, contest;
      r = (d == 0) ? req0 : req1;
      u = (d == 0) ? urg0 : urg1;
      f = (d == 0) ? free0 : free1;
      if (rst) begin
        m_owner[d] = 0;
        m_extra[d] = 0;
        m_allow[d] = 0;
        m_lock[d]  = 1'b0;
      end else begin
        model_grant(d, g);
        contest = !m_lock[d] && (r != '0);
        if (contest) begin
          model_arb(d, r, u, win, keep_turn);
          if (keep_turn) begin
            m_extra[d]++;
          end else begin
            m_owner[d] = win;
            m_extra[d] = 0;
            m_allow[d] = weight_of(d, win);
          end
        end
        if (d == 1) begin
          if ((g & f) != '0) m_lock[d] = 1'b0;
          else if (contest)  m_lock[d] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    logic [N-1:0] e0, e1;
    forever begin
      @(negedge clk);
      model_grant(0, e0);
      model_grant(1, e1);
      cmp("model_dut0", gnt0, e0);
      cmp("model_dut1", gnt1, e1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int d, input logic [N-1:0] exp);
    @(negedge clk);
    cmp(name, (d == 0) ? gnt0 : gnt1, exp);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      wt0[i] = '0;
      wt1[i] = '0;
    end
  endtask

  initial begin
    logic [N-1:0] rr_exp [5];
    logic [N-1:0] w_exp  [9];
    logic [N-1:0] d_exp  [7];
    rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    w_exp  = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
    d_exp  = '{4'b1000, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};

    rst = 1'b1;
    req0 = '0; req1 = '0; free0 = '0; free1 = '0; urg0 = '0; urg1 = '0;
    for (int i = 0; i < N; i++) begin
      wt0[i] = '0;
      wt1[i] = '0;
    end
    step();
    req0 = 4'b1111;
    req1 = 4'b1111;
    @(negedge clk);
    cmp("reset_grant0", gnt0, 4'b0000);
    cmp("reset_grant1", gnt1, 4'b0000);
    step();
    rst  = 1'b0;
    req0 = '0;
    req1 = '0;
    @(negedge clk);
    cmp("idle_grant0", gnt0, 4'b0000);
    cmp("idle_grant1", gnt1, 4'b0000);
    step();

    // Plain round-robin.
    req0 = 4'b1111;
    for (int i = 0; i < 5; i++) lit("rr_weight0", 0, rr_exp[i]);

    // Requester 1 weight 2: three grants per turn.
    req0 = '0;
    do_reset();
    wt0[1] = 2'd2;
    req0   = 4'b1111;
    for (int i = 0; i < 9; i++) lit("weight2_seq", 0, w_exp[i]);

    // Requester 1 weight 3 drops after two grants, later gets a full turn back.
    req0 = '0;
    do_reset();
    wt0[1] = 2'd3;
    req0   = 4'b1111;
    lit("drop_first", 0, 4'b0010);
    lit("drop_second", 0, 4'b0010);
    req0 = 4'b1101;
    lit("drop_forfeit", 0, 4'b0100);
    req0 = 4'b1111;
    for (int i = 0; i < 7; i++) lit("drop_reload", 0, d_exp[i]);

    // Hold-until-free instance.
    req0 = '0;
    do_reset();
    req1 = 4'b0101;
    lit("keep_grab", 1, 4'b0100);
    req1 = 4'b0000;
    for (int i = 0; i < 4; i++) lit("keep_hold", 1, 4'b0100);
    free1 = 4'b0100;
    lit("keep_free_cycle", 1, 4'b0100);
    free1 = 4'b0000;
    req1  = 4'b0101;
    lit("keep_next", 1, 4'b0001);
    req1 = 4'b0000;
    lit("keep_hold_again", 1, 4'b0001);
    rst = 1'b1;
    @(negedge clk);
    cmp("keep_reset_mid_hold", gnt1, 4'b0000);
    step();
    rst = 1'b0;
    step();

`ifdef TBCM_WRR_ARBITER_URGENT_EN
    do_reset();
    wt0[1] = 2'd3;
    req0   = 4'b1111;
    lit("urg_owner_a", 0, 4'b0010);
    lit("urg_owner_b", 0, 4'b0010);
    req0 = 4'b1010;
    urg0 = 4'b1000;
    lit("urg_preempt", 0, 4'b1000);
    lit("urg_repeat", 0, 4'b1000);
    urg0 = 4'b0000;
    lit("urg_cleared", 0, 4'b0010);
    req0 = '0;
    do_reset();
`endif

    // Random traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      req0  = N'($urandom);
      req1  = ($urandom_range(0, 2) == 0) ? 4'b0000 : N'($urandom);
      free0 = N'($urandom);
      free1 = ($urandom_range(0, 2) == 0) ? N'($urandom) : 4'b0000;
`ifdef TBCM_WRR_ARBITER_URGENT_EN
      urg0 = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b0000;
      urg1 = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b0000;
`endif
      if ($urandom_range(0, 15) == 0) wt0[$urandom_range(0, N-1)] = WW'($urandom);
      if ($urandom_range(0, 15) == 0) wt1[$urandom_range(0, N-1)] = WW'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tbcm_weighted_round_robin_arbiter.md
# tbcm_weighted_round_robin_arbiter

Parametrised N-way weighted round-robin arbiter for shared-resource access inside tbcm subsystems. Each requester owns a programmable weight. After winning, a requester may keep the grant for up to weight+1 consecutive arbitrations before priority rotates to the next requester. Grant is combinational from the request, with optional hold-until-free locking, and a compile-time urgent-request class that arbitrates ahead of normal traffic.

## Interface
- REQUESTS, 2, number of requesters (≥2).
- WEIGHT_WIDTH, 4, width of each per-requester weight.
- KEEP_RESULT, 1, 1: grant held until the holder asserts its `i_free` bit; 0: grant re-evaluated every cycle.
- INITIAL_GRANT, 1, one-hot rotation owner after reset; arbitration starts searching at the bit above it.
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_request  input  REQUESTS  request vector.
- i_weight  input  REQUESTS×WEIGHT_WIDTH  per-requester weight (unpacked array); quasi-static.
- o_grant  output  REQUESTS  one-hot or zero grant.
- i_free  input  REQUESTS  release strobe; used only when KEEP_RESULT=1.
- i_urgent  input  REQUESTS  urgent qualifier; present only with TBCM_WRR_ARBITER_URGENT_EN.

## Operation
- State:
  - `owner` (one-hot, reset INITIAL_GRANT).
  - `credit` (WEIGHT_WIDTH bits, reset 0).
  - `busy` (reset 0; constant 0 when KEEP_RESULT=0).
- Arbitration (`grab`) occurs when `busy`=0 and `i_request`≠0.
- Stay rule:
  - Condition: the `owner` bit is requesting, `credit`≠0, and the owner is not preempted by urgency.
  - Result: winner=`owner`, and `credit` decrements by 1.
- Rotate rule (stay rule not met):
  - Winner is the first requesting bit strictly after `owner`, wrapping modulo REQUESTS. If only `owner` requests, it wins again.
  - `owner` becomes the winner, and `credit` loads `i_weight[winner]`.
- Weight w therefore gives at most w+1 consecutive grants. w=0 is plain round-robin.
- An owner that drops its request forfeits its remaining credit. Rotation then starts after it.
- `i_weight` is sampled only on rotate. Changes mid-turn take effect at that requester's next rotate.
- o_grant:
  - Winner on `grab`.
  - `owner` while `busy`.
  - Otherwise 0.
- Busy (KEEP_RESULT=1):
  - Clears when (o_grant & i_free)≠0. Clear has priority.
  - Otherwise sets on `grab`.
  - Same-cycle grant+free is a one-cycle transaction with no lock.
  - While `busy`, requests are ignored and `credit` is frozen.
  - `i_free` bits outside the grant are ignored.

## Timing
- Reset values:
  - o_grant=0 while rst=1.
  - owner=INITIAL_GRANT, credit=0, busy=0.
- Grant latency is zero cycles: o_grant follows `i_request` combinationally in the `grab` cycle.
- State updates on the next rising edge.
- KEEP_RESULT=1:
  - The grant stays stable from the `grab` cycle through the cycle in which the matching `i_free` is asserted, inclusive.
  - The next `grab` is possible in the following cycle.
- Reset mid-operation:
  - Immediate o_grant=0; busy and credit clear; owner returns to INITIAL_GRANT.
  - No pending credit survives reset.
- Invariant: $onehot0(o_grant), checked by assertion.
- Elaboration check: INITIAL_GRANT must be one-hot.

## Configuration
- TBCM_WRR_ARBITER_URGENT_EN defined:
  - The `i_urgent` port exists.
  - If (i_request & i_urgent)≠0, arbitration is restricted to that set with the same stay/rotate rules.
  - A non-urgent owner with credit is preempted: rotate, credit reloaded from the urgent winner.
  - Does not break an active `busy` lock.
- Undefined: no `i_urgent` port; all requests are one class.

## Structure
- Package `tbcm_arbiter_pkg`:
  - Type `tbcm_rr_index_t` helper.
  - Functions for one-hot rotate and `$onehot` check, shared with tbcm_round_robin_arbiter.
- Sub-module `tbcm_rr_picker`:
  - Combinational.
  - Inputs: request, pointer.
  - Output: first set request strictly after the pointer, with wrap.
  - Instantiated once per class when urgent is enabled.

## Test plan
All scenarios: REQUESTS=4, WEIGHT_WIDTH=2, INITIAL_GRANT=4'b0001.
- Reset: rst=1 with i_request=4'b1111 -> o_grant=0. After release with i_request=0 -> o_grant=0.
- KEEP_RESULT=0, weights all 0, i_request=4'b1111 -> grants 0010, 0100, 1000, 0001, 0010 on consecutive cycles.
- KEEP_RESULT=0, i_weight[1]=2, others 0, all requesting -> grant sequence 0010×3, then 0100, 1000, 0001, then 0010×3.
- KEEP_RESULT=0, i_weight[1]=3, requester 1 drops its request after 2 grants -> next grant 0100. When requester 1 later wins again it gets credit 3 reloaded.
- KEEP_RESULT=1, i_request=4'b0101 -> 0100 granted and held for 5 cycles with i_free=0 even after the request drops. i_free=4'b0100 on cycle 6 -> o_grant=0100 that cycle, 0001 the next. Reset asserted mid-hold -> o_grant=0 immediately.
- URGENT_EN, i_weight[1]=3, owner 0010 mid-turn, i_urgent=1000 with i_request=1010 -> next grant 1000. Requester 1 regains the grant only after the urgent request clears.
